zkbdmus_ld: RTL
===============

# zkbdmus_ld

Upstream loader for the keyboard/mouse/joystick port mux. It takes the byte stream from the SPI slave (one byte per strobe, frames delimited by a frame-start pulse) and decodes a command byte. It assembles multi-byte keyboard snapshots in a shadow register and drives the strobe/data pairs that the port mux latches. Partial or aborted frames never reach the outputs.

## Interface
- TIMEOUT, 4096: inter-byte timeout in fclk cycles; an open frame idle this long is abandoned.
- fclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: SPI select asserted, a new frame begins.
- in_data  in  8  received byte, valid when in_stb=1.
- in_stb  in  1  one-cycle byte-valid strobe.
- kbd_out  out  40  keyboard matrix snapshot, bit=1 means key pressed.
- kbd_stb  out  1  one-cycle pulse: kbd_out just updated.
- mus_out  out  8  shared payload for mouse X/Y/buttons and Kempston.
- mus_xstb, mus_ystb, mus_btnstb, kj_stb  out  1 each  one-cycle pulse: mus_out holds the respective value.
- err_stb  out  1  one-cycle pulse: unknown command, or timeout/abort of an open frame.

## Operation
- Command codes: 0x10 KBD (5 payload bytes), 0x20 MUS_X, 0x21 MUS_Y, 0x22 MUS_BTN, 0x23 KJ (1 payload byte each). Any other code is unknown.
- States:
  - IDLE: ignores in_stb; frame_start -> CMD.
  - CMD: the next in_stb byte is decoded. KBD -> KBD with idx=0. MUS_* or KJ -> ONE. Unknown -> DISCARD with err_stb.
  - KBD: each in_stb writes shadow[8*idx+7:8*idx] and increments idx (3 bits). On idx=4, kbd_out <= shadow including this byte, kbd_stb pulses, and the state goes to DISCARD.
  - ONE: the first in_stb sets mus_out <= byte, pulses the matching strobe (selected by the latched low command bits), and the state goes to DISCARD.
  - DISCARD: swallows bytes until frame_start.
- frame_start in any state -> CMD.
  - Open KBD/ONE are aborted without updating outputs; err_stb pulses if the frame was aborted in KBD or ONE.
  - frame_start with in_stb in the same cycle: frame_start has priority, and that byte is decoded as the command byte.
- Timeout: a counter clears on frame_start or in_stb and increments otherwise while in CMD/KBD/ONE. On reaching TIMEOUT-1 the state goes to IDLE, err_stb pulses, and outputs are not updated. The counter saturates; it is not counted in IDLE/DISCARD.
- The shadow register is not cleared between frames. Only a complete 5-byte KBD frame reaches kbd_out.
- Extra bytes after the payload are ignored (DISCARD) with no error.

## Timing
- Reset values: state IDLE; kbd_out 0; mus_out 0; all strobes 0; idx 0; counter 0.
- Rst mid-frame: next cycle in IDLE with outputs at reset values; no strobe fires.
- Latency:
  - The final payload byte captured at edge N produces data and strobe both registered at edge N, visible in cycle N+1.
  - Data stays valid at least until the next strobe of the same kind, so the consumer may latch on the strobe cycle.
- Strobes are exactly one cycle wide and mutually exclusive. err_stb never coincides with a data strobe.
- Back-to-back in_stb on consecutive cycles is supported at full rate.

## Structure
- Shared package zkbdmus_pkg:
  - Command code constants CMD_KBD, CMD_MUSX, CMD_MUSY, CMD_MUSBTN, CMD_KJ.
  - State enum {IDLE, CMD, KBD, ONE, DISCARD}.
  - KBD_BYTES=5.
- One sub-module, zkbdmus_tmo: the parameterised saturating timeout counter with clear/enable inputs and an expire pulse.
- FSM, shadow register and output registers stay in the top.

## Test plan
- Reset then frame_start, bytes 10 01 02 04 08 80 -> one kbd_stb one cycle after the last byte; kbd_out=0x8008040201; no err_stb.
- frame_start, 21 5A -> mus_ystb single pulse, mus_out=0x5A; further byte 33 -> no strobe; then frame_start, 23 1F -> kj_stb, mus_out=0x1F.
- frame_start, 10 AA BB, then frame_start with byte 22 in the same cycle, then 07 -> err_stb on the abort; mus_btnstb with mus_out=0x07; kbd_out unchanged and no kbd_stb.
- frame_start, 10 11 22, then idle TIMEOUT cycles -> err_stb exactly at TIMEOUT-1 idle cycles and state IDLE; next lone bytes 33 44 55 ignored with no strobe.
- frame_start, 7F 01 -> err_stb on the 7F byte; no data strobes.
- rst asserted after 3 KBD payload bytes, then a full KBD frame of 01 02 03 04 05 -> kbd_out=0x0504030201 with one kbd_stb; no stale byte leakage.

Source files
------------

// File: rtl/zkbdmus_pkg.sv
// Shared definitions for the keyboard/mouse port-mux loader: command codes,
// FSM states and payload decode helpers.
package zkbdmus_pkg;

  localparam logic [7:0] CMD_KBD    = 8'h10;
  localparam logic [7:0] CMD_MUSX   = 8'h20;
  localparam logic [7:0] CMD_MUSY   = 8'h21;
  localparam logic [7:0] CMD_MUSBTN = 8'h22;
  localparam logic [7:0] CMD_KJ     = 8'h23;

  localparam int KBD_BYTES = 5;
  localparam int KBD_W     = 8 * KBD_BYTES;

  // Fixed encodings so the state register stays compatible with older dumps.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    KBD     = 3'd2,
    ONE     = 3'd3,
    DISCARD = 3'd4
  } state_e;

  // One-byte commands share the upper six bits; the low two pick the target.
  typedef struct packed {
    logic x;
    logic y;
    logic btn;
    logic kj;
  } one_stb_t;

  function automatic logic is_one_cmd(input logic [7:0] b);
    return b[7:2] == CMD_MUSX[7:2];
  endfunction

  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_KBD) || is_one_cmd(b);
  endfunction

  function automatic one_stb_t one_decode(input logic [1:0] sel);
    one_stb_t s;
    s     = '0;
    s.x   = (sel == CMD_MUSX[1:0]);
    s.y   = (sel == CMD_MUSY[1:0]);
    s.btn = (sel == CMD_MUSBTN[1:0]);
    s.kj  = (sel == CMD_KJ[1:0]);
    return s;
  endfunction

endpackage

// File: rtl/zkbdmus_tmo.sv
// Saturating inter-byte timeout counter. Counts enabled, non-cleared cycles
// and pulses expire on the increment that reaches TIMEOUT-1.
module zkbdmus_tmo #(
  parameter int TIMEOUT = 4096
) (
  input  logic fclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt;

  // Clear wins over counting; hold at the top value once reached.
  always_ff @(posedge fclk) begin
    if (rst)                         cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (en && cnt != CNT_LAST)  cnt <= cnt + 1'b1;
  end

  // Fires exactly once: only the step from TIMEOUT-2 to TIMEOUT-1 qualifies.
  assign expire = en && !clr && (cnt == CNT_PRE);

endmodule

// File: rtl/zkbdmus_ld.sv
// Loader between the SPI slave byte stream and the keyboard/mouse port mux.
// Decodes a command byte per frame, assembles keyboard snapshots in a shadow
// register and emits one-cycle strobe/data pairs. Aborted, timed-out or
// partial frames never touch the outputs.
module zkbdmus_ld
  import zkbdmus_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [7:0]       in_data,
  input  logic             in_stb,
  output logic [KBD_W-1:0] kbd_out,
  output logic             kbd_stb,
  output logic [7:0]       mus_out,
  output logic             mus_xstb,
  output logic             mus_ystb,
  output logic             mus_btnstb,
  output logic             kj_stb,
  output logic             err_stb
);

  localparam logic [2:0] LAST_IDX = 3'(KBD_BYTES - 1);

  state_e                     state, state_nx, eff;
  logic [2:0]                 idx;
  logic [1:0]                 sel;
  logic [KBD_BYTES-1:0][7:0]  shadow;
  logic [KBD_BYTES-1:0][7:0]  kbd_next;
  one_stb_t                   dec;

  logic tmo_en, tmo_clr, expire;
  logic cmd_take, cmd_unknown, abort;
  logic kbd_wr, kbd_done, one_wr;

  // frame_start overrides the current state, so a byte arriving with it is
  // treated as the command byte of the new frame.
  assign eff         = frame_start ? CMD : state;
  assign abort       = frame_start && (state == KBD || state == ONE);
  assign cmd_take    = in_stb && (eff == CMD);
  assign cmd_unknown = cmd_take && !is_known_cmd(in_data);
  assign kbd_wr      = in_stb && (eff == KBD);
  assign kbd_done    = kbd_wr && (idx == LAST_IDX);
  assign one_wr      = in_stb && (eff == ONE);
  assign dec         = one_decode(sel);

  assign tmo_en  = (state == CMD) || (state == KBD) || (state == ONE);
  assign tmo_clr = frame_start || in_stb;

  zkbdmus_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .fclk   (fclk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (expire)
  );

  // Next state: decode in CMD, close the frame once the payload completes.
  always_comb begin
    state_nx = eff;
    case (eff)
      CMD: if (in_stb) begin
        if (in_data == CMD_KBD)     state_nx = KBD;
        else if (is_one_cmd(in_data)) state_nx = ONE;
        else                        state_nx = DISCARD;
      end
      KBD:     if (kbd_done) state_nx = DISCARD;
      ONE:     if (in_stb)   state_nx = DISCARD;
      default: ;
    endcase
    if (expire) state_nx = IDLE;
  end

  // State register.
  always_ff @(posedge fclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Byte index and latched one-byte target, both set by the command byte.
  always_ff @(posedge fclk) begin
    if (rst) begin
      idx <= '0;
      sel <= '0;
    end else if (cmd_take) begin
      idx <= '0;
      sel <= in_data[1:0];
    end else if (kbd_wr) begin
      idx <= idx + 1'b1;
    end
  end

  // Shadow snapshot; deliberately kept across frames, only kbd_out is gated.
  always_ff @(posedge fclk) begin
    if (rst) shadow <= '0;
    else if (kbd_wr)
      for (int b = 0; b < KBD_BYTES; b++)
        if (idx == 3'(b)) shadow[b] <= in_data;
  end

  // The final byte bypasses the shadow so data and strobe land together.
  always_comb begin
    kbd_next                = shadow;
    kbd_next[KBD_BYTES-1]   = in_data;
  end

  // Keyboard output register and strobe.
  always_ff @(posedge fclk) begin
    if (rst) begin
      kbd_out <= '0;
      kbd_stb <= 1'b0;
    end else begin
      kbd_stb <= kbd_done;
      if (kbd_done) kbd_out <= kbd_next;
    end
  end

  // Shared mouse/joystick payload and its per-target strobes.
  always_ff @(posedge fclk) begin
    if (rst) begin
      mus_out    <= '0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
    end else begin
      mus_xstb   <= one_wr && dec.x;
      mus_ystb   <= one_wr && dec.y;
      mus_btnstb <= one_wr && dec.btn;
      kj_stb     <= one_wr && dec.kj;
      if (one_wr) mus_out <= in_data;
    end
  end

  // Error pulse: unknown command, aborted payload frame, or timeout.
  always_ff @(posedge fclk) begin
    if (rst) err_stb <= 1'b0;
    else     err_stb <= cmd_unknown || abort || expire;
  end

endmodule
